// File: rtl/divu_seq_hilo_pkg.sv
// Shared opcodes and FSM state type for the sequential divider and its Hi/Lo registers.
package divu_seq_hilo_pkg;

  localparam logic [5:0] AND     = 6'b100100;
  localparam logic [5:0] OR      = 6'b100101;
  localparam logic [5:0] ADD     = 6'b100000;
  localparam logic [5:0] SUB     = 6'b100010;
  localparam logic [5:0] SLT     = 6'b101010;
  localparam logic [5:0] SRL     = 6'b000010;
  localparam logic [5:0] DIVU    = 6'b011011;
  localparam logic [5:0] HILO_WR = 6'b111111;
  localparam logic [5:0] MFHI    = 6'b010000;
  localparam logic [5:0] MFLO    = 6'b010010;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/divu_seq_hilo_hilo_regs.sv
// Hi/Lo result registers with write enable and the MFHI/MFLO read mux.
module hilo_regs
  import divu_seq_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we) begin
      hi_q <= hi_in;
      lo_q <= lo_in;
    end
  end

  always_comb begin
    dataOut = '0;
    if (Signal == MFHI) begin
      dataOut = hi_q;
    end else if (Signal == MFLO) begin
      dataOut = lo_q;
    end
  end

endmodule

// File: rtl/divu_seq_hilo.sv
// Sequential restoring unsigned divider, one step per DIVU edge, committing to Hi/Lo on HILO_WR.
// Optional divide-by-zero flag output dz when DIVU_DIVZERO_FLAG_EN is defined.
module divu_seq_hilo
  import divu_seq_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
`ifdef DIVU_DIVZERO_FLAG_EN
  ,
  output logic             dz
`endif
);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;

  logic             is_divu;
  logic             start;
  logic             hilo_we;
  logic [WIDTH-1:0] src_rem;
  logic [WIDTH-1:0] src_quo;
  logic [WIDTH-1:0] src_dvsr;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  assign is_divu = (Signal == DIVU);
  assign start   = is_divu && (state != RUN);
  assign hilo_we = (state == DONE) && (Signal == HILO_WR);

  // On a starting edge the step runs on the fresh operands so load and step 1 share the edge.
  always_comb begin
    src_rem  = start ? '0 : rem;
    src_quo  = start ? dataA : quo;
    src_dvsr = start ? dataB : dvsr;
    t        = {src_rem, src_quo[WIDTH-1]};
    diff     = t - {1'b0, src_dvsr};
    step_rem = t[WIDTH-1:0];
    step_quo = {src_quo[WIDTH-2:0], 1'b0};
    if (t >= {1'b0, src_dvsr}) begin
      step_rem = diff[WIDTH-1:0];
      step_quo = {src_quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef DIVU_DIVZERO_FLAG_EN
      dz    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (is_divu) begin
            dvsr  <= dataB;
            rem   <= step_rem;
            quo   <= step_quo;
            count <= CNT_W'(1);
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef DIVU_DIVZERO_FLAG_EN
            dz    <= (dataB == '0);
`endif
          end else if (hilo_we) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (is_divu) begin
            rem   <= step_rem;
            quo   <= step_quo;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            // Any other control word aborts; partial results are simply left unused.
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo_regs (
    .clk    (clk),
    .reset  (reset),
    .we     (hilo_we),
    .hi_in  (rem),
    .lo_in  (quo),
    .Signal (Signal),
    .dataOut(dataOut)
  );

endmodule

// File: tb/tb_divu_seq_hilo.sv
// Directed self-checking bench for divu_seq_hilo.
module tb_divu_seq_hilo;
  import divu_seq_hilo_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
`ifdef DIVU_DIVZERO_FLAG_EN
  logic        dz;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  divu_seq_hilo dut (
    .clk    (clk),
    .reset  (reset),
    .Signal (Signal),
    .dataA  (dataA),
    .dataB  (dataB),
    .dataOut(dataOut),
    .busy   (busy),
    .done   (done)
`ifdef DIVU_DIVZERO_FLAG_EN
    ,
    .dz     (dz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a control word for one rising edge, then settle 1 time unit past it.
  task automatic edge_with(input logic [5:0] sig);
    Signal = sig;
    @(posedge clk);
    #1;
  endtask

  task automatic run_divu(input logic [31:0] a, input logic [31:0] b, input int n);
    dataA = a;
    dataB = b;
    for (int i = 0; i < n; i++) edge_with(DIVU);
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    Signal = MFHI;
    dataA  = '0;
    dataB  = '0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
    n_checks++;
    if (dataOut !== 32'h0) $display("FAIL reset_hi got %h want 0", dataOut); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    Signal = MFLO;
    #1;
    n_checks++;
    if (dataOut !== 32'h0) $display("FAIL reset_lo got %h want 0", dataOut); else n_pass++;
  endtask

  task automatic test_basic;
    run_divu(32'd100, 32'd7, 1);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy_e1 got %0b want 1", busy); else n_pass++;
    run_divu(32'd100, 32'd7, 30);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL basic_e31 got busy=%0b done=%0b want busy=1 done=0", busy, done);
    else n_pass++;
    run_divu(32'd100, 32'd7, 1);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1)
      $display("FAIL basic_e32 got busy=%0b done=%0b want busy=0 done=1", busy, done);
    else n_pass++;
    edge_with(ADD);
    n_checks++;
    if (done !== 1'b1) $display("FAIL basic_hold_done got %0b want 1", done); else n_pass++;
    edge_with(HILO_WR);
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_clr got %0b want 0", done); else n_pass++;
    Signal = MFLO;
    #1;
    n_checks++;
    if (dataOut !== 32'd14) $display("FAIL basic_lo got %0d want 14", dataOut); else n_pass++;
    Signal = MFHI;
    #1;
    n_checks++;
    if (dataOut !== 32'd2) $display("FAIL basic_hi got %0d want 2", dataOut); else n_pass++;
    Signal = ADD;
    #1;
    n_checks++;
    if (dataOut !== 32'd0) $display("FAIL basic_other got %0d want 0", dataOut); else n_pass++;
  endtask

  task automatic test_divzero;
    run_divu(32'h1234, 32'h0, 1);
`ifdef DIVU_DIVZERO_FLAG_EN
    n_checks++;
    if (dz !== 1'b1) $display("FAIL dz_set got %0b want 1", dz); else n_pass++;
`endif
    run_divu(32'h1234, 32'h0, 31);
    edge_with(HILO_WR);
    Signal = MFLO;
    #1;
    n_checks++;
    if (dataOut !== 32'hFFFF_FFFF) $display("FAIL dz_lo got %h want ffffffff", dataOut);
    else n_pass++;
    Signal = MFHI;
    #1;
    n_checks++;
    if (dataOut !== 32'h1234) $display("FAIL dz_hi got %h want 1234", dataOut); else n_pass++;
  endtask

  task automatic test_extremes;
    run_divu(32'hFFFF_FFFF, 32'd1, 32);
    edge_with(HILO_WR);
    Signal = MFLO;
    #1;
    n_checks++;
    if (dataOut !== 32'hFFFF_FFFF) $display("FAIL max_div1_lo got %h want ffffffff", dataOut);
    else n_pass++;
    Signal = MFHI;
    #1;
    n_checks++;
    if (dataOut !== 32'h0) $display("FAIL max_div1_hi got %h want 0", dataOut); else n_pass++;
    run_divu(32'd5, 32'hFFFF_FFFF, 1);
`ifdef DIVU_DIVZERO_FLAG_EN
    n_checks++;
    if (dz !== 1'b0) $display("FAIL dz_clr got %0b want 0", dz); else n_pass++;
`endif
    run_divu(32'd5, 32'hFFFF_FFFF, 31);
    edge_with(HILO_WR);
    Signal = MFLO;
    #1;
    n_checks++;
    if (dataOut !== 32'h0) $display("FAIL small_lo got %h want 0", dataOut); else n_pass++;
    Signal = MFHI;
    #1;
    n_checks++;
    if (dataOut !== 32'd5) $display("FAIL small_hi got %h want 5", dataOut); else n_pass++;
  endtask

  // Hi=5, Lo=0 remain from the previous test.
  task automatic test_abort;
    run_divu(32'd100, 32'd7, 10);
    edge_with(ADD);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_state got busy=%0b done=%0b want 0 0", busy, done);
    else n_pass++;
    edge_with(HILO_WR);
    n_checks++;
    if (done !== 1'b0) $display("FAIL abort_done got %0b want 0", done); else n_pass++;
    Signal = MFHI;
    #1;
    n_checks++;
    if (dataOut !== 32'd5) $display("FAIL abort_hi got %0d want 5", dataOut); else n_pass++;
    Signal = MFLO;
    #1;
    n_checks++;
    if (dataOut !== 32'd0) $display("FAIL abort_lo got %0d want 0", dataOut); else n_pass++;
    // HILO_WR mid-run must not write either.
    run_divu(32'd100, 32'd7, 5);
    edge_with(HILO_WR);
    Signal = MFHI;
    #1;
    n_checks++;
    if (dataOut !== 32'd5) $display("FAIL run_wr_hi got %0d want 5", dataOut); else n_pass++;
  endtask

  task automatic test_async_reset;
    run_divu(32'd1000, 32'd3, 15);
    Signal = MFHI;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL arst_flags got busy=%0b done=%0b want 0 0", busy, done);
    else n_pass++;
    n_checks++;
    if (dataOut !== 32'h0) $display("FAIL arst_hi got %h want 0", dataOut); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    run_divu(32'd20, 32'd3, 32);
    n_checks++;
    if (done !== 1'b1) $display("FAIL arst_done got %0b want 1", done); else n_pass++;
    edge_with(HILO_WR);
    Signal = MFLO;
    #1;
    n_checks++;
    if (dataOut !== 32'd6) $display("FAIL arst_lo got %0d want 6", dataOut); else n_pass++;
    Signal = MFHI;
    #1;
    n_checks++;
    if (dataOut !== 32'd2) $display("FAIL arst_hi2 got %0d want 2", dataOut); else n_pass++;
  endtask

  task automatic test_back_to_back;
    run_divu(32'd9, 32'd2, 32);
    n_checks++;
    if (done !== 1'b1) $display("FAIL b2b_first_done got %0b want 1", done); else n_pass++;
    run_divu(32'd50, 32'd8, 1);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_restart got busy=%0b done=%0b want 1 0", busy, done);
    else n_pass++;
    // Operands changed after the starting edge must be ignored.
    run_divu(32'd999, 32'd1, 31);
    edge_with(HILO_WR);
    Signal = MFLO;
    #1;
    n_checks++;
    if (dataOut !== 32'd6) $display("FAIL b2b_lo got %0d want 6", dataOut); else n_pass++;
    Signal = MFHI;
    #1;
    n_checks++;
    if (dataOut !== 32'd2) $display("FAIL b2b_hi got %0d want 2", dataOut); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divzero();
    test_extremes();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
